// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, CSRRx op codes,
// trap-related bit positions and mtvec mode encodings.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIP_MSIP     = 3;
    localparam int unsigned MIP_MTIP     = 7;
    localparam int unsigned MIP_MEIP     = 11;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1
    } mtvec_mode_e;

    // funct3[1:0] selects write / set / clear; the immediate forms share the encoding.
    function automatic logic [31:0] csr_rmw(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
        case (op)
            2'b01:   return operand;
            2'b10:   return old_val | operand;
            2'b11:   return old_val & ~operand;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_m_if.sv
// CSR instruction access bus between the write-back stage (master) and the CSR file (slave).
interface csr_file_m_if;
    logic [2:0]  funct3_i;
    logic [11:0] addr_i;
    logic [31:0] data_i;
    logic [4:0]  rs1_i;
    logic        is_csr_i;
    logic [31:0] data_out_o;
    logic        illegal_csr_o;

    modport master (
        output funct3_i, addr_i, data_i, rs1_i, is_csr_i,
        input  data_out_o, illegal_csr_o
    );

    modport slave (
        input  funct3_i, addr_i, data_i, rs1_i, is_csr_i,
        output data_out_o, illegal_csr_o
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half CSR write; a write to either half
// replaces that cycle's increment and leaves the other half untouched.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_en_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);
    logic [63:0] value_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_reg <= '0;
        end else if (we_lo_i) begin
            value_reg[31:0] <= wdata_i;
        end else if (we_hi_i) begin
            value_reg[63:32] <= wdata_i;
        end else if (inc_en_i) begin
            value_reg <= value_reg + 64'd1;
        end
    end

    assign value_o = value_reg;
endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRx read-modify-write, trap entry / MRET state and redirect PC.
// Define CSR_COUNTERS_EN to add mcycle/minstret and their read-only user aliases.
module csr_file_m
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MISA_VAL  = 32'h40000100,
    parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    csr_file_m_if.slave        csr,
    input  logic               we_exc_i,
    input  logic [31:0]        mcause_d_i,
    input  logic [31:0]        mepc_d_i,
    input  logic [31:0]        mtval_d_i,
    input  logic               sel_exc_nret_i,
    input  logic               retire_i,
    input  logic               xint_meip_i,
    input  logic               xint_mtip_i,
    input  logic               xint_msip_i,
    output logic [31:0]        exc_ret_addr_o,
    output logic               irq_pending_o
);
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic        irq_pending_reg;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic [31:0] old_val;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic [31:0] mtvec_base;
    logic        implemented;
    logic        read_only;
    logic        wr_intent;
    logic        illegal;
    logic        csr_we;

    // MPP is hardwired to machine mode.
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

    always_comb begin
        mip_val           = '0;
        mip_val[MIP_MEIP] = xint_meip_i;
        mip_val[MIP_MTIP] = xint_mtip_i;
        mip_val[MIP_MSIP] = xint_msip_i;
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] cnt_val [2];
    logic [1:0]  cnt_inc;

    assign cnt_inc = {retire_i, 1'b1};

    // Counter 0 is mcycle, counter 1 is minstret; their addresses differ by 2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        localparam logic [11:0] LO_ADDR = CSR_MCYCLE + 12'(2 * gi);
        localparam logic [11:0] HI_ADDR = CSR_MCYCLEH + 12'(2 * gi);

        csr_counter64 u_cnt (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .inc_en_i (cnt_inc[gi]),
            .we_lo_i  (csr_we && (csr.addr_i == LO_ADDR)),
            .we_hi_i  (csr_we && (csr.addr_i == HI_ADDR)),
            .wdata_i  (wdata),
            .value_o  (cnt_val[gi])
        );
    end
`endif

    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (csr.addr_i)
            CSR_MSTATUS:  old_val = mstatus_val;
            CSR_MISA:     old_val = MISA_VAL;
            CSR_MIE:      old_val = mie_reg;
            CSR_MTVEC:    old_val = mtvec_reg;
            CSR_MSCRATCH: old_val = mscratch_reg;
            CSR_MEPC:     old_val = mepc_reg;
            CSR_MCAUSE:   old_val = mcause_reg;
            CSR_MTVAL:    old_val = mtval_reg;
            CSR_MIP:      old_val = mip_val;
            CSR_MHARTID:  old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,   CSR_CYCLE:    old_val = cnt_val[0][31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   old_val = cnt_val[0][63:32];
            CSR_MINSTRET, CSR_INSTRET:  old_val = cnt_val[1][31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = cnt_val[1][63:32];
`endif
            default:      implemented = 1'b0;
        endcase
    end

    always_comb begin
        wr_intent = 1'b0;
        case (csr.funct3_i)
            F3_RW, F3_RWI:                 wr_intent = 1'b1;
            F3_RS, F3_RC, F3_RSI, F3_RCI:  wr_intent = (csr.rs1_i != 5'd0);
            default:                       wr_intent = 1'b0;
        endcase
    end

    assign operand   = csr.funct3_i[2] ? {27'b0, csr.rs1_i} : csr.data_i;
    assign wdata     = csr_rmw(csr.funct3_i[1:0], old_val, operand);
    assign read_only = (csr.addr_i == CSR_MISA) || (csr.addr_i == CSR_MHARTID) ||
                       (csr.addr_i == CSR_MIP)  || (csr.addr_i[11:8] == 4'hC);
    assign illegal   = csr.is_csr_i && (!implemented || (wr_intent && read_only));
    // Trap entry and MRET both pre-empt a CSR write in the same cycle.
    assign csr_we    = csr.is_csr_i && wr_intent && !illegal && !we_exc_i && !sel_exc_nret_i;

    assign csr.data_out_o    = old_val;
    assign csr.illegal_csr_o = illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= MTVEC_RST;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else if (we_exc_i) begin
            mepc_reg         <= mepc_d_i & ~32'd3;
            mcause_reg       <= mcause_d_i;
            mtval_reg        <= mtval_d_i;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (sel_exc_nret_i) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_we) begin
            case (csr.addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_reg  <= wdata[MSTATUS_MIE];
                    mstatus_mpie_reg <= wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_reg      <= wdata & 32'h0000_0888;
                // Reserved modes 2 and 3 collapse to direct.
                CSR_MTVEC:    mtvec_reg    <= {wdata[31:2], wdata[1] ? MTVEC_DIRECT : wdata[1:0]};
                CSR_MSCRATCH: mscratch_reg <= wdata;
                CSR_MEPC:     mepc_reg     <= wdata & ~32'd3;
                CSR_MCAUSE:   mcause_reg   <= wdata;
                CSR_MTVAL:    mtval_reg    <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_pending_reg <= 1'b0;
        end else begin
            irq_pending_reg <= mstatus_mie_reg && (|(mip_val & mie_reg));
        end
    end

    assign irq_pending_o = irq_pending_reg;

    assign mtvec_base = {mtvec_reg[31:2], 2'b00};

    always_comb begin
        exc_ret_addr_o = mtvec_base;
        if (sel_exc_nret_i) begin
            exc_ret_addr_o = mepc_reg;
        end else if ((mtvec_reg[1:0] == MTVEC_VECTORED) && mcause_d_i[31]) begin
            exc_ret_addr_o = mtvec_base + {25'b0, mcause_d_i[4:0], 2'b00};
        end
    end
endmodule

// File: tb/tb_csr_file_m.sv
// Directed-vector bench for csr_file_m; each comparison prints one line.
// Build with CSR_COUNTERS_EN defined to exercise the 64-bit counters.
module tb_csr_file_m;
    logic        clk = 1'b0;
    logic        rst;
    logic        we_exc;
    logic [31:0] mcause_d;
    logic [31:0] mepc_d;
    logic [31:0] mtval_d;
    logic        sel_exc_nret;
    logic        retire;
    logic        meip, mtip, msip;
    logic [31:0] exc_ret_addr;
    logic        irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    csr_file_m_if bus ();

    csr_file_m #(
        .HART_ID   (32'd0),
        .MISA_VAL  (32'h40000100),
        .MTVEC_RST (32'h00000000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .csr            (bus.slave),
        .we_exc_i       (we_exc),
        .mcause_d_i     (mcause_d),
        .mepc_d_i       (mepc_d),
        .mtval_d_i      (mtval_d),
        .sel_exc_nret_i (sel_exc_nret),
        .retire_i       (retire),
        .xint_meip_i    (meip),
        .xint_mtip_i    (mtip),
        .xint_msip_i    (msip),
        .exc_ret_addr_o (exc_ret_addr),
        .irq_pending_o  (irq_pending)
    );

    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %-22s got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %-22s 0x%08h", tag, got);
        end
    endtask

    // Advance one clock edge, then drop all one-cycle strobes.
    task automatic step();
        @(posedge clk);
        #1;
        bus.is_csr_i = 1'b0;
        we_exc       = 1'b0;
        sel_exc_nret = 1'b0;
    endtask

    // Present a CSR instruction; the caller may sample, then calls step() to commit.
    task automatic csr_set(input logic [2:0] f3, input logic [11:0] a,
                           input logic [31:0] d, input logic [4:0] r);
        bus.funct3_i = f3;
        bus.addr_i   = a;
        bus.data_i   = d;
        bus.rs1_i    = r;
        bus.is_csr_i = 1'b1;
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_set(3'b001, a, d, 5'd1);
        step();
    endtask

    // Non-writing read (CSRRS with rs1 = x0).
    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_set(3'b010, a, 32'h0, 5'd0);
        check_eq(tag, bus.data_out_o, exp);
        bus.is_csr_i = 1'b0;
    endtask

    task automatic chk_illegal(input string tag, input logic [2:0] f3,
                               input logic [11:0] a, input logic [4:0] r, input logic exp);
        csr_set(f3, a, 32'h1, r);
        check_eq(tag, {31'b0, bus.illegal_csr_o}, {31'b0, exp});
        bus.is_csr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we_exc = 1'b0; sel_exc_nret = 1'b0; retire = 1'b0;
        mcause_d = '0; mepc_d = '0; mtval_d = '0;
        meip = 1'b0; mtip = 1'b0; msip = 1'b0;
        bus.funct3_i = 3'b000; bus.addr_i = '0; bus.data_i = '0;
        bus.rs1_i = '0; bus.is_csr_i = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_irq", {31'b0, irq_pending}, 32'h0);
        chk_csr("rst_mstatus", 12'h300, 32'h00001800);
        chk_csr("rst_mhartid", 12'hF14, 32'h0);
        chk_csr("rst_misa",    12'h301, 32'h40000100);
        chk_csr("rst_mtvec",   12'h305, 32'h0);
        chk_csr("rst_mepc",    12'h341, 32'h0);
        check_eq("rst_exc_ret", exc_ret_addr, 32'h0);

        // mscratch RW then non-writing RS
        csr_set(3'b001, 12'h340, 32'hDEADBEEF, 5'd3);
        check_eq("rw_old_val", bus.data_out_o, 32'h0);
        step();
        csr_set(3'b010, 12'h340, 32'hFFFFFFFF, 5'd0);
        check_eq("rs0_rdata", bus.data_out_o, 32'hDEADBEEF);
        check_eq("rs0_illegal", {31'b0, bus.illegal_csr_o}, 32'h0);
        step();
        chk_csr("rs0_nowrite", 12'h340, 32'hDEADBEEF);

        // Legality
        chk_illegal("ill_misa_rd",   3'b010, 12'h301, 5'd0, 1'b0);
        chk_illegal("ill_misa_wr",   3'b001, 12'h301, 5'd1, 1'b1);
        chk_illegal("ill_hartid_wr", 3'b101, 12'hF14, 5'd0, 1'b1);
        chk_illegal("ill_mip_set",   3'b110, 12'h344, 5'd4, 1'b1);
        chk_illegal("ill_unimpl",    3'b010, 12'h7C0, 5'd0, 1'b1);
        chk_illegal("ill_c00_wr",    3'b001, 12'hC00, 5'd1, 1'b1);
        bus.addr_i = 12'h7C0;
        #1;
        check_eq("ill_gated", {31'b0, bus.illegal_csr_o}, 32'h0);
        csr_set(3'b001, 12'h301, 32'h0, 5'd1);
        step();
        chk_csr("ill_nochange", 12'h301, 32'h40000100);
`ifdef CSR_COUNTERS_EN
        chk_illegal("cnt_mcycle_wr", 3'b001, 12'hB00, 5'd1, 1'b0);
`else
        chk_illegal("cnt_disabled", 3'b010, 12'hB00, 5'd0, 1'b1);
`endif

        // WARL masks
        csr_wr(12'h300, 32'hFFFFFFFF);
        chk_csr("warl_mstatus", 12'h300, 32'h00001888);
        csr_wr(12'h300, 32'h0);
        csr_wr(12'h341, 32'h00000207);
        chk_csr("warl_mepc", 12'h341, 32'h00000204);
        csr_wr(12'h305, 32'h00000302);
        chk_csr("warl_mtvec", 12'h305, 32'h00000300);
        csr_wr(12'h304, 32'hFFFFFFFF);
        chk_csr("warl_mie", 12'h304, 32'h00000888);
        csr_wr(12'h305, 32'h0);

        // Trap entry then MRET
        csr_set(3'b110, 12'h300, 32'h0, 5'd8);
        step();
        chk_csr("rsi_mstatus", 12'h300, 32'h00001808);
        we_exc = 1'b1; mcause_d = 32'h2; mepc_d = 32'h103; mtval_d = 32'h13;
        #1;
        check_eq("trap_vec_direct", exc_ret_addr, 32'h0);
        step();
        chk_csr("trap_mepc",    12'h341, 32'h00000100);
        chk_csr("trap_mcause",  12'h342, 32'h00000002);
        chk_csr("trap_mtval",   12'h343, 32'h00000013);
        chk_csr("trap_mstatus", 12'h300, 32'h00001880);
        sel_exc_nret = 1'b1;
        #1;
        check_eq("mret_target", exc_ret_addr, 32'h00000100);
        step();
        chk_csr("mret_mstatus", 12'h300, 32'h00001888);

        // Vectored mtvec
        csr_wr(12'h305, 32'h00000201);
        chk_csr("mtvec_vect", 12'h305, 32'h00000201);
        we_exc = 1'b1; mcause_d = 32'h2; mepc_d = 32'h400; mtval_d = 32'h0;
        #1;
        check_eq("vect_sync", exc_ret_addr, 32'h00000200);
        mcause_d = 32'h80000007;
        #1;
        check_eq("vect_irq7", exc_ret_addr, 32'h0000021C);
        step();
        chk_csr("vect_mstatus", 12'h300, 32'h00001880);

        // Interrupt pending, trap+CSR collision, MRET+CSR collision
        csr_set(3'b110, 12'h300, 32'h0, 5'd8);
        step();
        csr_wr(12'h304, 32'h00000080);
        mtip = 1'b1;
        #1;
        check_eq("irq_before", {31'b0, irq_pending}, 32'h0);
        chk_csr("mip_mtip", 12'h344, 32'h00000080);
        step();
        check_eq("irq_latency", {31'b0, irq_pending}, 32'h1);
        csr_set(3'b001, 12'h340, 32'h12345678, 5'd1);
        we_exc = 1'b1; mcause_d = 32'h80000007; mepc_d = 32'h500; mtval_d = 32'h0;
        step();
        chk_csr("trap_drops_wr", 12'h340, 32'hDEADBEEF);
        step();
        check_eq("irq_cleared", {31'b0, irq_pending}, 32'h0);
        mtip = 1'b0;
        csr_set(3'b001, 12'h340, 32'h00000055, 5'd1);
        sel_exc_nret = 1'b1;
        #1;
        check_eq("mret_target2", exc_ret_addr, 32'h00000500);
        step();
        chk_csr("mret_drops_wr", 12'h340, 32'hDEADBEEF);
        chk_csr("mret2_mstatus", 12'h300, 32'h00001888);

`ifdef CSR_COUNTERS_EN
        // 64-bit wrap
        csr_wr(12'hB00, 32'hFFFFFFFF);
        csr_wr(12'hB80, 32'hFFFFFFFF);
        chk_csr("mcycle_lo_set", 12'hB00, 32'hFFFFFFFF);
        chk_csr("mcycle_hi_set", 12'hB80, 32'hFFFFFFFF);
        step();
        chk_csr("mcycle_lo_wrap", 12'hB00, 32'h0);
        chk_csr("mcycle_hi_wrap", 12'hB80, 32'h0);
        chk_csr("cycle_alias",    12'hC00, 32'h0);
        // No carry from a suppressed increment
        csr_wr(12'hB80, 32'h00000005);
        csr_wr(12'hB00, 32'hFFFFFFFF);
        chk_csr("mcycle_hi_hold", 12'hB80, 32'h00000005);
        step();
        chk_csr("mcycle_hi_carry", 12'hB80, 32'h00000006);
        chk_csr("mcycle_lo_after", 12'hB00, 32'h0);
        // minstret counts retire only
        csr_wr(12'hB02, 32'h0);
        retire = 1'b1;
        step(); step(); step();
        retire = 1'b0;
        step();
        chk_csr("minstret_lo", 12'hB02, 32'h00000003);
        chk_csr("instret_alias", 12'hC02, 32'h00000003);
        chk_illegal("cycle_rw_ill", 3'b001, 12'hC00, 5'd1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Machine-mode CSR register file for the 5-stage RV32I core.
- Consumes the trap/return side-band from the write-back stage and executes the CSRRx read-modify-write instructions.
- Holds trap state: mstatus, mepc, mcause, mtval.
- Supplies the redirect PC: the trap vector on exception entry, or mepc on MRET.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h40000100, read-only misa value (RV32I).
- MTVEC_RST, 32'h00000000, reset value of mtvec.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- funct3_i  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- addr_i  in  12  CSR address
- data_i  in  32  rs1 register value
- rs1_i  in  5  rs1 index; zero-extended immediate for the *I ops
- is_csr_i  in  1  CSR instruction valid in WB this cycle
- we_exc_i  in  1  trap entry strobe
- mcause_d_i  in  32  cause for trap entry
- mepc_d_i  in  32  PC of the faulting instruction
- mtval_d_i  in  32  trap value
- sel_exc_nret_i  in  1  MRET strobe; selects mepc as the redirect target
- retire_i  in  1  one instruction retired
- xint_meip_i / xint_mtip_i / xint_msip_i  in  1 each  external, timer and software interrupt lines
- data_out_o  out  32  old CSR value; written to rd
- exc_ret_addr_o  out  32  redirect target
- illegal_csr_o  out  1  access to an unimplemented CSR, or write to a read-only CSR
- irq_pending_o  out  1  enabled interrupt pending

Behaviour:
- Reset: all writable CSRs are 0, except mtvec = MTVEC_RST.
  - mstatus.MPP reads 2'b11 (hardwired).
  - irq_pending_o = 0.
  - Combinational outputs reflect the reset state.
- Implemented CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mhartid 0xF14.
- Read: data_out_o is combinational from addr_i and gives the pre-write value in the same cycle.
- Operand: RW/RS/RC use data_i; RWI/RSI/RCI use {27'b0, rs1_i}.
  - RW writes the operand.
  - RS writes old | operand.
  - RC writes old & ~operand.
  - The write commits at the clock edge when is_csr_i is high.
- Write suppression: RS/RC/RSI/RCI with rs1_i == 0 performs no write. A read-only CSR read this way is legal.
- illegal_csr_o (combinational, gated by is_csr_i) asserts for:
  - an unimplemented address;
  - a write-intent op to misa, mhartid or mip, or to a 0xC00–0xCFF address.
  - When illegal_csr_o is high, no state changes.
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] are writable.
  - mie: only bits 11, 7 and 3 are writable.
  - mepc: bits [1:0] forced to 0.
  - mtvec: bits [1:0] are the mode; values 2 and 3 store as 0.
- mip is combinational: {meip, mtip, msip} at bits 11, 7, 3.
- Trap entry (we_exc_i), at the clock edge:
  - mepc <= mepc_d_i & ~3, mcause <= mcause_d_i, mtval <= mtval_d_i;
  - MPIE <= MIE, MIE <= 0.
- MRET (sel_exc_nret_i and not we_exc_i): MIE <= MPIE, MPIE <= 1.
- exc_ret_addr_o (combinational):
  - sel_exc_nret_i high: current mepc.
  - Otherwise, direct mode: {mtvec[31:2], 2'b00}.
  - Vectored mode with mcause_d_i[31] set: base + 4*mcause_d_i[4:0].
- Simultaneous events:
  - we_exc_i has priority over MRET and over any CSR write in the same cycle; the CSR write is dropped.
  - MRET with is_csr_i in the same cycle: MRET wins.
- irq_pending_o is registered: MIE & |(mip & mie). It has 1-cycle latency and is cleared in the cycle after trap entry because MIE = 0.

Optional Feature:
- Macro CSR_COUNTERS_EN.
- When defined, adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus read-only aliases cycle and instret (0xC00/0xC80, 0xC02/0xC82).
  - mcycle increments every cycle; minstret increments when retire_i is high.
  - A CSR write to either half takes precedence over that cycle's increment. The other half is held unchanged; no carry into it from the suppressed increment.
  - Both counters wrap from 2^64-1 to 0.
- When not defined, these addresses are illegal and retire_i is ignored.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - funct3 op codes;
  - mstatus/mip bit positions (MIE = 3, MPIE = 7, MSIP = 3, MTIP = 7, MEIP = 11);
  - mtvec mode encodings.
- One sub-module, csr_counter64: increment enable, per-half write enable, 32-bit write data, 64-bit value. It is instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- Reset, then read 0x300 -> 32'h00001800. Read 0xF14 -> HART_ID. Read 0x301 -> MISA_VAL.
- CSRRW 0x340 with data_i = 32'hDEADBEEF, then CSRRS 0x340 with rs1_i = 0 -> data_out_o = 32'hDEADBEEF, no write, illegal_csr_o = 0.
- mstatus = 8, then we_exc_i with mcause_d_i = 2, mepc_d_i = 32'h103, mtval_d_i = 32'h13 -> mepc = 32'h100, mstatus = 32'h1880, exc_ret_addr_o = mtvec base. Then sel_exc_nret_i -> exc_ret_addr_o = 32'h100; next cycle mstatus = 32'h1888.
- mtvec = 32'h201 (vectored), we_exc_i with mcause_d_i = 32'h80000007 -> exc_ret_addr_o = 32'h21C.
- MIE = 1, mie = 32'h80, xint_mtip_i pulse -> irq_pending_o = 1 one cycle later. we_exc_i plus CSRRW mscratch in the same cycle -> mscratch unchanged.
- CSR_COUNTERS_EN: write mcycle low = 32'hFFFFFFFF, high = 32'hFFFFFFFF -> counter wraps to 0 after 1 cycle. CSRRW 0xC00 -> illegal_csr_o = 1.
